// File: rtl/dl_uart_pkg.sv
// Shared constants and the FSM state encoding for the dl_platform UART
// receive and transmit paths.
package dl_uart_pkg;

  localparam int DL_UART_CLK_HZ = 10_000_000;
  localparam int DL_UART_BAUD   = 115200;
  // Rounded to the nearest integer: 10 MHz / 115200 -> 87
  localparam int DL_UART_CLKS_PER_BIT = (DL_UART_CLK_HZ + DL_UART_BAUD / 2) / DL_UART_BAUD;
  localparam int DL_UART_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } dl_uart_state_e;

endpackage

// File: rtl/dl_uart_rx_fifo.sv
// Receive byte FIFO. When a push and a pop land on the same edge with the
// FIFO full, the pop is taken first so the push still succeeds.
module dl_uart_rx_fifo
  import dl_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk10m,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DL_UART_DATA_W-1:0] push_data,
  input  logic                      pop,
  output logic [DL_UART_DATA_W-1:0] head,
  output logic                      empty,
  output logic                      drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DL_UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dl_uart_rx.sv
// 8N1 UART receiver for the MCU command link, with a small receive FIFO.
// Build option DL_UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge (after line seen high once)
// START | timing to start-bit middle, rejecting glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit, push byte or flag framing error
// BREAK | line held low after a framing error, wait for it to go high
module dl_uart_rx
  import dl_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DL_UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk10m,
  input  logic                      rst_n,
  input  logic                      rxd,
  output logic [DL_UART_DATA_W-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam logic [2:0] ST_IDLE  = 3'(S_IDLE);
  localparam logic [2:0] ST_START = 3'(S_START);
  localparam logic [2:0] ST_DATA  = 3'(S_DATA);
  localparam logic [2:0] ST_STOP  = 3'(S_STOP);
  localparam logic [2:0] ST_BREAK = 3'(S_BREAK);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;
`ifdef DL_UART_RX_MAJORITY_EN
  localparam int SAMP = MID + 1;
`else
  localparam int SAMP = MID;
`endif
  localparam logic [CW-1:0] SAMP_CNT = CW'(SAMP);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic                      sync1;
  logic                      rxs;
  logic                      sample;
  logic [2:0]                state;
  logic [CW-1:0]             cnt;
  logic [2:0]                idx;
  logic [DL_UART_DATA_W-1:0] shift;
  logic [1:0]                warm;
  logic                      armed;
  logic                      push;
  logic                      drop;
  logic                      empty;

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

`ifdef DL_UART_RX_MAJORITY_EN
  // hist holds rxs from the two cycles before the decision cycle
  logic [1:0] hist;
  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rxs};
  end
  assign sample = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign sample = rxs;
`endif

  // The synchroniser's reset value is not a real observation of the line, so
  // arming waits until rxs carries a post-reset sample that is high.
  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      warm <= {warm[0], 1'b1};
      if (warm[1] && rxs) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && !rxs) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == SAMP_CNT) begin
            cnt <= '0;
            idx <= '0;
            state <= sample ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST_CNT) begin
            shift[idx] <= sample;
            cnt        <= '0;
            if (idx == 3'd7) state <= ST_STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (sample) begin
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push = (state == ST_STOP) && (cnt == LAST_CNT) && sample;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= drop;
  end

  dl_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk10m    (clk10m),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift),
    .pop       (rx_ready),
    .head      (rx_data),
    .empty     (empty),
    .drop      (drop)
  );

  assign rx_valid = !empty;

endmodule

// File: tb/tb_dl_uart_rx.sv
// Directed bench for dl_uart_rx; honours DL_UART_RX_MAJORITY_EN for the
// sample-point shift and the mid-bit glitch scenario.
module tb_dl_uart_rx;

  localparam int CPB = 87;
`ifdef DL_UART_RX_MAJORITY_EN
  localparam int MAJ    = 1;
  localparam int GL_OFF = 44;
`else
  localparam int MAJ    = 0;
  localparam int GL_OFF = 20;
`endif
  // start detect at P2, stop decision at P(46+MAJ+9*87)
  localparam int BUSY_CYC = 827 + MAJ;
  localparam int PUSH_NEG = 829 + MAJ;

  logic       clk10m = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rxd    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rcv[$];
  int fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, valid_cnt = 0;

  always #50 clk10m = ~clk10m;

  dl_uart_rx dut (
    .clk10m    (clk10m),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk10m) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) rcv.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (busy)      busy_cnt++;
      if (rx_valid)  valid_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk10m);
  endtask

  // Called at a negedge; glitch (gl > 0) inverts each data bit for one cycle at offset gl.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gl);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      if (gl > 0 && i >= 1 && i <= 8) begin
        repeat (gl) @(negedge clk10m);
        rxd = ~fr[i];
        @(negedge clk10m);
        rxd = fr[i];
        repeat (CPB - gl - 1) @(negedge clk10m);
      end else begin
        repeat (CPB) @(negedge clk10m);
      end
    end
  endtask

  task automatic test_reset;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_single;
    int q0, fe0, b0, v0;
    q0 = rcv.size(); fe0 = fe_cnt; b0 = busy_cnt; v0 = valid_cnt;
    rx_ready = 1'b1;
    send_byte(8'hA5, 1'b1, 0);
    idle(20);
    vectors++; if (rcv.size() - q0 != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", rcv.size() - q0); end
    vectors++; if (rcv.size() > q0 && rcv[q0] !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", rcv[q0]); end
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - fe0); end
    vectors++; if (busy_cnt - b0 != BUSY_CYC) begin miscompares++; $display("FAIL single_busy_cycles: got %0d want %0d", busy_cnt - b0, BUSY_CYC); end
    vectors++; if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL single_valid_cycles: got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_glitch;
    int q0, fe0, v0;
    q0 = rcv.size(); fe0 = fe_cnt; v0 = valid_cnt;
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(150);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy: got %b want 0", busy); end
    vectors++; if (valid_cnt - v0 != 0) begin miscompares++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0); end
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fe0); end
    vectors++; if (rcv.size() != q0) begin miscompares++; $display("FAIL glitch_bytes: got %0d want 0", rcv.size() - q0); end
  endtask

  task automatic test_frame_err;
    int q0, fe0;
    q0 = rcv.size(); fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0, 0);
    idle(3000);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL break_busy: got %b want 1", busy); end
    rxd = 1'b1;
    idle(100);
    vectors++; if (fe_cnt - fe0 != 1) begin miscompares++; $display("FAIL break_frame_err_count: got %0d want 1", fe_cnt - fe0); end
    vectors++; if (rcv.size() != q0) begin miscompares++; $display("FAIL break_no_byte: got %0d want 0", rcv.size() - q0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL break_exit_busy: got %b want 0", busy); end
    send_byte(8'h81, 1'b1, 0);
    idle(20);
    vectors++; if (rcv.size() - q0 != 1 || rcv[rcv.size() - 1] !== 8'h81) begin miscompares++; $display("FAIL after_break_data: got %0d bytes want 1 (0x81)", rcv.size() - q0); end
    vectors++; if (fe_cnt - fe0 != 1) begin miscompares++; $display("FAIL after_break_frame_err: got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun;
    int q0, ov0;
    logic [7:0] exp;
    q0 = rcv.size(); ov0 = ov_cnt;
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 0);
    idle(20);
    vectors++; if (ov_cnt - ov0 != 1) begin miscompares++; $display("FAIL overrun_count: got %0d want 1", ov_cnt - ov0); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL overrun_valid: got %b want 1", rx_valid); end
    vectors++; if (rx_data !== 8'h01) begin miscompares++; $display("FAIL overrun_head: got %h want 01", rx_data); end
    rx_ready = 1'b1;
    idle(10);
    vectors++; if (rcv.size() - q0 != 4) begin miscompares++; $display("FAIL overrun_drain_count: got %0d want 4", rcv.size() - q0); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i + 1);
      vectors++;
      if (q0 + i >= rcv.size() || rcv[q0 + i] !== exp) begin
        miscompares++;
        $display("FAIL overrun_drain_%0d: got %h want %h", i, (q0 + i < rcv.size()) ? rcv[q0 + i] : 8'hxx, exp);
      end
    end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL overrun_empty: got %b want 0", rx_valid); end
  endtask

  task automatic test_full_pop;
    int q0, ov0;
    logic [7:0] exp [5];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    q0 = rcv.size(); ov0 = ov_cnt;
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(exp[i], 1'b1, 0);
    idle(5);
    fork
      send_byte(8'h55, 1'b1, 0);
      begin
        repeat (PUSH_NEG) @(negedge clk10m);
        rx_ready = 1'b1;
        @(negedge clk10m);
        rx_ready = 1'b0;
      end
    join
    idle(20);
    vectors++; if (ov_cnt - ov0 != 0) begin miscompares++; $display("FAIL fullpop_overrun: got %0d want 0", ov_cnt - ov0); end
    rx_ready = 1'b1;
    idle(10);
    vectors++; if (rcv.size() - q0 != 5) begin miscompares++; $display("FAIL fullpop_count: got %0d want 5", rcv.size() - q0); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (q0 + i >= rcv.size() || rcv[q0 + i] !== exp[i]) begin
        miscompares++;
        $display("FAIL fullpop_order_%0d: got %h want %h", i, (q0 + i < rcv.size()) ? rcv[q0 + i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int q0, fe0;
    rx_ready = 1'b1;
    rxd = 1'b0;
    idle(5 * CPB);
    rst_n = 1'b0;
    idle(10);
    rst_n = 1'b1;
    q0 = rcv.size(); fe0 = fe_cnt;
    idle(300);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_low_line_busy: got %b want 0", busy); end
    rxd = 1'b1;
    idle(100);
    send_byte(8'h7E, 1'b1, 0);
    idle(20);
    vectors++; if (fe_cnt - fe0 != 0) begin miscompares++; $display("FAIL rst_frame_err: got %0d want 0", fe_cnt - fe0); end
    vectors++; if (rcv.size() - q0 != 1 || rcv[rcv.size() - 1] !== 8'h7E) begin miscompares++; $display("FAIL rst_then_7e: got %0d bytes want 1 (0x7e)", rcv.size() - q0); end
  endtask

  task automatic test_glitch_bits;
    int q0;
    q0 = rcv.size();
    rx_ready = 1'b1;
    send_byte(8'h5A, 1'b1, GL_OFF);
    idle(20);
    vectors++; if (rcv.size() - q0 != 1 || rcv[rcv.size() - 1] !== 8'h5A) begin miscompares++; $display("FAIL glitch_bits_5a: got %0d bytes want 1 (0x5a)", rcv.size() - q0); end
  endtask

  initial begin
    idle(3);
    test_reset;
    rst_n = 1'b1;
    idle(10);
    test_single;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_full_pop;
    test_reset_midframe;
    test_glitch_bits;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
